cex_sweep_ctrl: RTL

- Sequential controller that exhaustively enumerates assignments to the error-formula miter and reports counterexamples.
- The miter is the combinational check F(x,y) & Skolem(x,y') & ~F(x,y').
- Sits between the test/host logic and the miter instance: drives every x/y/y' input, samples the miter output after a fixed evaluation latency, records the first failing assignment and counts all failing assignments.
- Used to certify a candidate Skolem function (zero hits means valid).

---
 rtl/cex_sweep_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/cex_sweep_ctrl.sv
// Exhaustive sweep controller for the Skolem error-formula miter: steps asg through every
// x/y/y' assignment, samples err_in EVAL_LAT cycles later, keeps the first hit and a hit count.
module cex_sweep_ctrl #(
    parameter int  NX       = 1,
    parameter int  NY       = 2,
    parameter int  EVAL_LAT = 1,
    localparam int W        = NX + 2 * NY,
    localparam int CW       = W + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          first_only,
    input  logic          abort,
    input  logic          err_in,
    output logic [W-1:0]  asg,
    output logic          busy,
    output logic          done,
    output logic          found,
    output logic [W-1:0]  cex,
    output logic [CW-1:0] cex_cnt
);

    localparam int              WCW     = (EVAL_LAT > 1) ? $clog2(EVAL_LAT) : 1;
    localparam logic [WCW-1:0]  WLAST   = WCW'(EVAL_LAT - 1);
    localparam logic [W-1:0]    ASG_MAX = {W{1'b1}};
    localparam logic [CW-1:0]   CNT_MAX = {CW{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t          state_r,   state_s;
    logic [W-1:0]    asg_r,     asg_s;
    logic [W-1:0]    cex_r,     cex_s;
    logic [CW-1:0]   cnt_r,     cnt_s;
    logic [WCW-1:0]  wcnt_r,    wcnt_s;
    logic            found_r,   found_s;
    logic            fo_r,      fo_s;
    logic            busy_r,    busy_s;
    logic            done_r,    done_s;
    logic            last_asg_s;
    logic            sample_s;

    assign last_asg_s = (asg_r == ASG_MAX);
    assign sample_s   = (wcnt_r == WLAST);

    // Next-state and next-value logic; busy/done are decoded from the next state so they register cleanly
    always_comb begin
        state_s = state_r;
        asg_s   = asg_r;
        cex_s   = cex_r;
        cnt_s   = cnt_r;
        wcnt_s  = wcnt_r;
        found_s = found_r;
        fo_s    = fo_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    asg_s   = {W{1'b0}};
                    cex_s   = {W{1'b0}};
                    cnt_s   = {CW{1'b0}};
                    wcnt_s  = {WCW{1'b0}};
                    found_s = 1'b0;
                    fo_s    = first_only;
                    state_s = EVAL;
                end else begin
                    state_s = IDLE;
                end
            end
            EVAL: begin
                // abort wins over a sample landing on the same edge; that sample is dropped
                if (abort) begin
                    state_s = IDLE;
                end else if (!sample_s) begin
                    wcnt_s = wcnt_r + WCW'(1);
                end else begin
                    if (err_in) begin
                        found_s = 1'b1;
                        cnt_s   = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CW'(1);
                        if (cnt_r == {CW{1'b0}}) begin
                            cex_s = asg_r;
                        end else begin
                            cex_s = cex_r;
                        end
                    end else begin
                        found_s = found_r;
                    end
                    if ((err_in && fo_r) || last_asg_s) begin
                        state_s = FIN;
                    end else begin
                        asg_s  = asg_r + W'(1);
                        wcnt_s = {WCW{1'b0}};
                    end
                end
            end
            FIN: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        busy_s = (state_s == EVAL);
        done_s = (state_s == FIN);
    end

    // State and result registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            asg_r   <= {W{1'b0}};
            cex_r   <= {W{1'b0}};
            cnt_r   <= {CW{1'b0}};
            wcnt_r  <= {WCW{1'b0}};
            found_r <= 1'b0;
            fo_r    <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            asg_r   <= asg_s;
            cex_r   <= cex_s;
            cnt_r   <= cnt_s;
            wcnt_r  <= wcnt_s;
            found_r <= found_s;
            fo_r    <= fo_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign asg     = asg_r;
    assign cex     = cex_r;
    assign cex_cnt = cnt_r;
    assign found   = found_r;
    assign busy    = busy_r;
    assign done    = done_r;

endmodule
